// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Coefficient value after reset: all ones turns the filter into a moving sum.
  localparam int COEF_RESET = 1;

  function automatic int out_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;

  assign prod = sample * coef;

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(OUT_W - PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/fir_filter_serial.sv
// Serial FIR filter: one MAC steps through the taps, one per clock, with a
// valid/ready sample input and runtime-loadable coefficients.
module fir_filter_serial
  import fir_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 4,
  localparam int OUT_W  = out_width(DATA_W, COEF_W, TAPS),
  localparam int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_valid
);

  state_t state, next_state;
  logic [ADDR_W-1:0]        idx;
  logic signed [DATA_W-1:0] delay [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [OUT_W-1:0]  acc;
  logic accept, last_tap, addr_ok, coef_take;

  assign in_ready  = (state == IDLE) && !clr;
  assign accept    = in_valid && in_ready;
  assign last_tap  = (idx == ADDR_W'(TAPS - 1));
  assign addr_ok   = (int'(coef_addr) < TAPS);
  assign coef_take = coef_we && (state == IDLE) && addr_ok;

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = MAC;
      MAC:  if (clr) next_state = IDLE;
            else if (last_tap) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      if (accept) idx <= '0;
      else if (state == MAC) idx <= idx + 1'b1;
    end
  end

  // NOTE: delay line and coefficient file are flops, so they take a reset value;
  // a RAM-based store would not be reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= COEF_W'(COEF_RESET);
      end
    end else begin
      if (clr) begin
        for (int i = 0; i < TAPS; i++) delay[i] <= '0;
      end else if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) delay[i] <= delay[i-1];
        delay[0] <= data_in;
      end
      // Write lands before the MAC starts, so a same-cycle sample sees it.
      if (coef_take) coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      out_valid <= (state == DONE) && !clr;
      if ((state == DONE) && !clr) data_out <= acc;
      coef_err  <= coef_we && !coef_take;
    end
  end

  fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept || clr),
    .en    ((state == MAC) && !clr),
    .sample(delay[idx]),
    .coef  (coef[idx]),
    .acc   (acc)
  );

endmodule

// File: tb/tb_fir_filter_serial.sv
// Scoreboard bench for fir_filter_serial: a tap-history model predicts each
// result and its arrival time; a monitor compares whenever out_valid fires.
module tb_fir_filter_serial;

  localparam int TAPS  = 4;
  localparam int OUT_W = 18;
  localparam int P     = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic [7:0]       data_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             coef_we = 1'b0;
  logic [1:0]       coef_addr = '0;
  logic [7:0]       coef_data = '0;
  logic             coef_err;
  logic [OUT_W-1:0] data_out;
  logic             out_valid;

  fir_filter_serial dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_err (coef_err),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  always #(P/2) clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] val;
    longint           t;
  } exp_t;

  exp_t sb[$];
  int   hist[TAPS];
  int   cm[TAPS];
  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  int   exp_err_pulses = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: output = sum over taps of history[k] * coefficient[k].
  function automatic logic [OUT_W-1:0] model_accept(input logic [7:0] d);
    longint s = 0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(d));
    for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(cm[k]);
    return s[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      cm[k]   = 1;
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && coef_err) err_pulses++;
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("data_out", longint'(data_out), longint'(e.val));
        check("latency", longint'($time) - e.t, longint'((TAPS + 1) * P + P / 2));
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [7:0] d, input bit we = 1'b0,
                      input logic [1:0] a = 2'd0, input logic [7:0] v = 8'd0);
    exp_t e;
    wait_ready("send");
    data_in = d; in_valid = 1'b1;
    coef_we = we; coef_addr = a; coef_data = v;
    @(posedge clk);
    if (we) cm[a] = int'($signed(v));
    e.val = model_accept(d);
    e.t   = longint'($time);
    sb.push_back(e);
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] v);
    wait_ready("write_coef");
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    @(posedge clk);
    cm[a] = int'($signed(v));
    #1;
    coef_we = 1'b0;
    check("coef_err_idle", coef_err, 0);
  endtask

  task automatic clr_idle(input bit with_valid);
    wait_ready("clr_idle");
    clr = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1; data_in = 8'd99;
    end
    #1;
    check("in_ready_during_clr", in_ready, 0);
    @(posedge clk);
    model_flush();
    #1;
    clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic expect_out(input string name, input logic [OUT_W-1:0] v);
    drain();
    check(name, longint'(data_out), longint'(v));
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    sb.delete();
    model_reset();
    in_valid = 1'b0; coef_we = 1'b0; clr = 1'b0;
    #1;
    check("rst_out_valid_async", out_valid, 0);
    step();
    step();
    rst = 1'b1;
    check("rst_data_out", longint'(data_out), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_err", coef_err, 0);
  endtask

  initial begin
    int      n;
    longint  tprev;
    logic    r;
    int      sel;

    // 1. reset, including an async reset during a computation
    do_reset();
    send(8'd50);
    step();
    step();
    do_reset();
    repeat (8) step();
    check("rst_mid_data_out", longint'(data_out), 0);
    send(8'd5);
    expect_out("t1_sample5", 18'd5);

    // 2. default moving sum of full-scale positive samples
    clr_idle(1'b0);
    send(8'h7F); expect_out("t2_1", 18'd127);
    send(8'h7F); expect_out("t2_2", 18'd254);
    send(8'h7F); expect_out("t2_3", 18'd381);
    send(8'h7F); expect_out("t2_4", 18'd508);

    // 3. negative full scale; clr wins over a simultaneous sample
    send(8'h80); send(8'h80); send(8'h80); send(8'h80);
    expect_out("t3_neg_full", 18'h3FE00);
    clr_idle(1'b1);
    send(8'hFA);
    expect_out("t3_after_clr", 18'h3FFFA);

    // 6. clr in MAC cycle 2 aborts with no result; line is flushed
    send(8'd7);
    void'(sb.pop_back());
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_flush();
    repeat (10) step();
    check("t6_data_out_held", longint'(data_out), longint'(18'h3FFFA));
    send(8'd20);
    expect_out("t6_after_abort", 18'd20);

    // 4. loaded coefficients {1,-1,0,0}
    write_coef(2'd0, 8'd1);
    write_coef(2'd1, 8'hFF);
    write_coef(2'd2, 8'd0);
    write_coef(2'd3, 8'd0);
    clr_idle(1'b0);
    send(8'd10); expect_out("t4_1", 18'd10);
    send(8'd10); expect_out("t4_2", 18'd0);
    send(8'd3);  expect_out("t4_3", 18'h3FFF9);

    // 5a. in_valid held high: one sample per IDLE visit
    wait_ready("held");
    in_valid = 1'b1; data_in = 8'd4;
    n = 0; tprev = 0;
    for (int c = 0; c < 3 * (TAPS + 2); c++) begin
      exp_t e;
      r = in_ready;
      @(posedge clk);
      if (r) begin
        e.val = model_accept(8'd4);
        e.t   = longint'($time);
        sb.push_back(e);
        if (n > 0) check("held_accept_interval", e.t - tprev, longint'((TAPS + 2) * P));
        tprev = e.t;
        n++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("held_accept_count", n, 3);
    drain();

    // 5b. coefficient write during MAC is dropped with an error pulse
    send(8'd9);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd5;
    step();
    coef_we = 1'b0;
    exp_err_pulses++;
    check("t5_coef_err_pulse", coef_err, 1);
    step();
    check("t5_coef_err_one_cycle", coef_err, 0);
    drain();
    send(8'd2);
    drain();

    // randomized mix: samples, idle and same-cycle coefficient writes, flushes
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 12) write_coef(2'($urandom), 8'($urandom));
      else if (sel < 17) clr_idle(1'($urandom));
      else if (sel < 32) send(8'($urandom), 1'b1, 2'($urandom), 8'($urandom));
      else send(8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    repeat (3) step();
    check("coef_err_pulse_count", err_pulses, exp_err_pulses);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
